// File: rtl/colour_block_frame_ctrl_if.sv
// Pixel stream in, per-frame result out (valid/ready) for the colour block
// frame controller. The slave view belongs to the controller.
interface colour_block_frame_ctrl_if #(
  parameter int X_W = 12,
  parameter int Y_W = 12
);
  logic [23:0]        pixel_in;
  logic               pix_valid;
  logic               sof;
  logic               eol;

  logic               res_valid;
  logic               res_ready;
  logic [X_W-1:0]     res_xmin;
  logic [X_W-1:0]     res_xmax;
  logic [Y_W-1:0]     res_ymin;
  logic [Y_W-1:0]     res_ymax;
  logic [X_W+Y_W-1:0] res_count;
  logic               res_found;

  modport master (
    output pixel_in, pix_valid, sof, eol, res_ready,
    input  res_valid, res_xmin, res_xmax, res_ymin, res_ymax, res_count, res_found
  );

  modport slave (
    input  pixel_in, pix_valid, sof, eol, res_ready,
    output res_valid, res_xmin, res_xmax, res_ymin, res_ymax, res_count, res_found
  );
endinterface

// File: rtl/colour_block_frame_ctrl.sv
// Frame-level controller for the colour block detector: tracks x/y over the
// pixel stream, classifies pixels against a programmable RGB window, keeps a
// per-frame bounding box and match count, and presents one result per frame.
module colour_block_frame_ctrl #(
  parameter int X_W         = 12,
  parameter int Y_W         = 12,
  parameter int FRAME_LINES = 480,
  parameter int MIN_COUNT   = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [23:0]                cfg_lo,
  input  logic [23:0]                cfg_hi,
  input  logic                       cfg_load,
  colour_block_frame_ctrl_if.slave   bus,
  output logic                       busy,
  output logic                       frame_err,
  output logic                       overrun
);

  localparam int C_W = X_W + Y_W;
  localparam logic [Y_W-1:0] LAST_Y = Y_W'(FRAME_LINES - 1);

  typedef enum logic [1:0] {IDLE, ACTIVE, REPORT} state_t;

  state_t         state, state_n;
  logic [23:0]    shadow_lo, shadow_hi, act_lo, act_hi;
  logic [X_W-1:0] x, xmin, xmax;
  logic [Y_W-1:0] y, ymin, ymax;
  logic [C_W-1:0] cnt;

  logic           take_sof, take_pix, hit, last;
  logic [23:0]    win_lo, win_hi;
  logic [X_W-1:0] cur_x, base_xmin, base_xmax, nxt_xmin, nxt_xmax;
  logic [Y_W-1:0] cur_y, base_ymin, base_ymax, nxt_ymin, nxt_ymax;
  logic [C_W-1:0] base_cnt, nxt_cnt;

  function automatic logic in_window(input logic [23:0] p, input logic [23:0] lo,
                                     input logic [23:0] hi);
    return (p[23:16] >= lo[23:16]) && (p[23:16] <= hi[23:16]) &&
           (p[15:8]  >= lo[15:8])  && (p[15:8]  <= hi[15:8])  &&
           (p[7:0]   >= lo[7:0])   && (p[7:0]   <= hi[7:0]);
  endfunction

  // Pixel classification, accumulator update and next state.
  // A sof pixel sees the window and accumulators it is about to install, so
  // it is evaluated as (0,0) of the new frame in the same cycle.
  always_comb begin
    take_sof  = bus.pix_valid & bus.sof;
    take_pix  = take_sof | (bus.pix_valid & (state == ACTIVE));
    win_lo    = act_lo;
    win_hi    = act_hi;
    if (take_sof) begin
      win_lo = cfg_load ? cfg_lo : shadow_lo;
      win_hi = cfg_load ? cfg_hi : shadow_hi;
    end
    cur_x     = take_sof ? '0 : x;
    cur_y     = take_sof ? '0 : y;
    base_xmin = take_sof ? '1 : xmin;
    base_xmax = take_sof ? '0 : xmax;
    base_ymin = take_sof ? '1 : ymin;
    base_ymax = take_sof ? '0 : ymax;
    base_cnt  = take_sof ? '0 : cnt;
    hit       = take_pix & in_window(bus.pixel_in, win_lo, win_hi);
    nxt_xmin  = base_xmin;
    nxt_xmax  = base_xmax;
    nxt_ymin  = base_ymin;
    nxt_ymax  = base_ymax;
    nxt_cnt   = base_cnt;
    if (hit) begin
      if (cur_x < base_xmin) nxt_xmin = cur_x;
      if (cur_x > base_xmax) nxt_xmax = cur_x;
      if (cur_y < base_ymin) nxt_ymin = cur_y;
      if (cur_y > base_ymax) nxt_ymax = cur_y;
      if (base_cnt != '1)    nxt_cnt  = base_cnt + 1'b1;
    end
    last    = take_pix & bus.eol & (cur_y == LAST_Y);
    state_n = state;
    case (state)
      IDLE, REPORT: state_n = take_sof ? (last ? REPORT : ACTIVE) : IDLE;
      ACTIVE:       if (last) state_n = REPORT;
      default:      state_n = IDLE;
    endcase
  end

  // Frame FSM with registered outputs, coordinate/accumulator state and the
  // result handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      shadow_lo     <= '0;
      shadow_hi     <= '1;
      act_lo        <= '0;
      act_hi        <= '1;
      x             <= '0;
      y             <= '0;
      xmin          <= '1;
      xmax          <= '0;
      ymin          <= '1;
      ymax          <= '0;
      cnt           <= '0;
      busy          <= 1'b0;
      frame_err     <= 1'b0;
      overrun       <= 1'b0;
      bus.res_valid <= 1'b0;
      bus.res_xmin  <= '0;
      bus.res_xmax  <= '0;
      bus.res_ymin  <= '0;
      bus.res_ymax  <= '0;
      bus.res_count <= '0;
      bus.res_found <= 1'b0;
    end else begin
      state     <= state_n;
      busy      <= (state_n == ACTIVE);
      frame_err <= (state == ACTIVE) & take_sof;
      overrun   <= 1'b0;

      if (cfg_load) begin
        shadow_lo <= cfg_lo;
        shadow_hi <= cfg_hi;
      end
      if (take_sof) begin
        act_lo <= win_lo;
        act_hi <= win_hi;
      end

      if (take_pix) begin
        xmin <= nxt_xmin;
        xmax <= nxt_xmax;
        ymin <= nxt_ymin;
        ymax <= nxt_ymax;
        cnt  <= nxt_cnt;
        if (bus.eol) begin
          x <= '0;
          y <= cur_y + 1'b1;
        end else begin
          x <= (cur_x == '1) ? cur_x : cur_x + 1'b1;
          y <= cur_y;
        end
      end

      // Accumulators still hold the finished frame here even if a new sof
      // is being taken this cycle; they are only overwritten at this edge.
      if (state == REPORT) begin
        bus.res_valid <= 1'b1;
        overrun       <= bus.res_valid & ~bus.res_ready;
        bus.res_count <= cnt;
        bus.res_found <= (cnt >= C_W'(MIN_COUNT));
        if (cnt == '0) begin
          bus.res_xmin <= '0;
          bus.res_xmax <= '0;
          bus.res_ymin <= '0;
          bus.res_ymax <= '0;
        end else begin
          bus.res_xmin <= xmin;
          bus.res_xmax <= xmax;
          bus.res_ymin <= ymin;
          bus.res_ymax <= ymax;
        end
      end else if (bus.res_valid & bus.res_ready) begin
        bus.res_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_colour_block_frame_ctrl.sv
// Directed bench for colour_block_frame_ctrl with a result scoreboard.
module tb_colour_block_frame_ctrl;

  localparam logic [23:0] OLD_LO  = 24'hC80000;  // R 200..255, G/B 0..50
  localparam logic [23:0] OLD_HI  = 24'hFF3232;
  localparam logic [23:0] NEW_LO  = 24'h00C800;  // G 200..255, R/B 0..50
  localparam logic [23:0] NEW_HI  = 24'h32FF32;
  localparam logic [23:0] MATCH_A = 24'hE01020;  // inside old window only
  localparam logic [23:0] MATCH_B = 24'h10E010;  // inside new window only

  typedef struct packed {
    logic [11:0] xmin;
    logic [11:0] xmax;
    logic [11:0] ymin;
    logic [11:0] ymax;
    logic [23:0] cnt;
    logic        found;
  } res_t;

  logic        clk, rst_n, cfg_load, busy, frame_err, overrun;
  logic [23:0] cfg_lo, cfg_hi;
  int          n_checks = 0, n_pass = 0, err_pulses = 0, ovr_pulses = 0;
  res_t        sb_q[$];

  colour_block_frame_ctrl_if #(.X_W(12), .Y_W(12)) bus ();

  colour_block_frame_ctrl #(.X_W(12), .Y_W(12), .FRAME_LINES(4), .MIN_COUNT(16)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .cfg_lo   (cfg_lo),
    .cfg_hi   (cfg_hi),
    .cfg_load (cfg_load),
    .bus      (bus),
    .busy     (busy),
    .frame_err(frame_err),
    .overrun  (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic res_t mk(input int xmin, input int xmax, input int ymin,
                              input int ymax, input int cnt, input logic found);
    res_t r;
    r.xmin = 12'(xmin); r.xmax = 12'(xmax);
    r.ymin = 12'(ymin); r.ymax = 12'(ymax);
    r.cnt = 24'(cnt); r.found = found;
    return r;
  endfunction

  function automatic res_t cur_res();
    res_t r;
    r.xmin = bus.res_xmin; r.xmax = bus.res_xmax;
    r.ymin = bus.res_ymin; r.ymax = bus.res_ymax;
    r.cnt = bus.res_count; r.found = bus.res_found;
    return r;
  endfunction

  // Monitor: every accepted result must match the oldest expected entry.
  always @(negedge clk) begin
    if (rst_n) begin
      if (frame_err) err_pulses++;
      if (overrun) ovr_pulses++;
      if (bus.res_valid && bus.res_ready) begin
        if (sb_q.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_result: got %h expected none", cur_res());
        end else begin
          check("result", cur_res(), sb_q.pop_front());
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  function automatic logic [23:0] pix_at(input int mode, input int x, input int y);
    case (mode)
      0: return ((x == 2 && y == 1) || (x == 5 && y == 1) || (x == 3 && y == 2)) ? MATCH_A : 24'h0;
      1: return MATCH_A;
      3: return (x == 1 && y == 0) ? MATCH_A : ((x == 6 && y == 3) ? MATCH_B : 24'h0);
      default: return 24'h0;
    endcase
  endfunction

  task automatic send_px(input logic [23:0] p, input logic s, input logic e, input logic ld);
    bus.pixel_in = p; bus.pix_valid = 1'b1; bus.sof = s; bus.eol = e; cfg_load = ld;
    @(posedge clk); #1;
    bus.pix_valid = 1'b0; bus.sof = 1'b0; bus.eol = 1'b0; cfg_load = 1'b0;
  endtask

  // Sends nlines 8-pixel lines starting with sof; cfg_load rides on the
  // first pixel of load_line (-1 for none). Returns 1ns after the last edge.
  task automatic send_frame(input int mode, input int load_line, input int nlines);
    for (int y = 0; y < nlines; y++)
      for (int x = 0; x < 8; x++) begin
        send_px(pix_at(mode, x, y), (x == 0 && y == 0), (x == 7), (y == load_line && x == 0));
        if (x == 0 && y == 0) check("busy_after_sof", busy, 1'b1);
      end
  endtask

  task automatic cycles(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic drain();
    for (int i = 0; i < 50 && sb_q.size() != 0; i++) cycles(1);
    check("drain", sb_q.size(), 0);
  endtask

  initial begin
    int e0, o0;
    rst_n = 1'b0; cfg_load = 1'b0; cfg_lo = '0; cfg_hi = '0;
    bus.pixel_in = '0; bus.pix_valid = 1'b0; bus.sof = 1'b0; bus.eol = 1'b0;
    bus.res_ready = 1'b1;
    #12;
    check("rst_res_valid", bus.res_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_frame_err", frame_err, 1'b0);
    check("rst_overrun", overrun, 1'b0);
    check("rst_result", cur_res(), mk(0, 0, 0, 0, 0, 0));
    @(posedge clk); #1; rst_n = 1'b1;
    cfg_lo = OLD_LO; cfg_hi = OLD_HI;
    send_px(24'h0, 1'b0, 1'b0, 1'b1);  // non-sof pixel: dropped, loads shadow
    check("idle_drop_busy", busy, 1'b0);

    // Sparse matches, result latency
    sb_q.push_back(mk(2, 5, 1, 2, 3, 0));
    send_frame(0, -1, 4);
    check("no_valid_at_report", bus.res_valid, 1'b0);
    cycles(1);
    check("valid_after_report", bus.res_valid, 1'b1);
    drain();

    // All matching, stalled consumer
    bus.res_ready = 1'b0;
    sb_q.push_back(mk(0, 7, 0, 3, 32, 1));
    send_frame(1, -1, 4);
    cycles(1);
    for (int i = 0; i < 10; i++) begin
      check("hold_valid", bus.res_valid, 1'b1);
      check("hold_result", cur_res(), mk(0, 7, 0, 3, 32, 1));
      cycles(1);
    end
    bus.res_ready = 1'b1;
    cycles(1);
    check("valid_drop", bus.res_valid, 1'b0);
    drain();

    // No matches
    sb_q.push_back(mk(0, 0, 0, 0, 0, 0));
    send_frame(2, -1, 4);
    drain();

    // Abort by sof at line 2, restart relative to the new sof
    e0 = err_pulses;
    send_frame(1, -1, 2);
    sb_q.push_back(mk(2, 5, 1, 2, 3, 0));
    send_frame(0, -1, 4);
    drain();
    check("frame_err_pulses", err_pulses - e0, 1);

    // Window change mid-frame, then on the sof cycle
    cfg_lo = NEW_LO; cfg_hi = NEW_HI;
    sb_q.push_back(mk(1, 1, 0, 0, 1, 0));
    send_frame(3, 2, 4);
    drain();
    sb_q.push_back(mk(6, 6, 3, 3, 1, 0));
    send_frame(3, -1, 4);
    drain();
    cfg_lo = OLD_LO; cfg_hi = OLD_HI;
    sb_q.push_back(mk(1, 1, 0, 0, 1, 0));
    send_frame(3, 0, 4);
    drain();

    // Back-to-back frames into a stalled consumer: frame 1 overwritten
    o0 = ovr_pulses;
    bus.res_ready = 1'b0;
    sb_q.push_back(mk(0, 7, 0, 3, 32, 1));
    send_frame(0, -1, 4);
    send_frame(1, -1, 4);
    cycles(3);
    check("overrun_once", ovr_pulses - o0, 1);
    bus.res_ready = 1'b1;
    drain();

    // Same, but consumer accepts on the REPORT cycle
    o0 = ovr_pulses;
    bus.res_ready = 1'b0;
    sb_q.push_back(mk(2, 5, 1, 2, 3, 0));
    send_frame(0, -1, 4);
    cycles(2);
    sb_q.push_back(mk(0, 7, 0, 3, 32, 1));
    send_frame(1, -1, 4);
    bus.res_ready = 1'b1;
    cycles(1);
    check("valid_kept_on_accept", bus.res_valid, 1'b1);
    cycles(2);
    check("no_overrun", ovr_pulses - o0, 0);
    drain();

    // Reset mid-frame restores the all-pass window
    send_frame(1, -1, 2);
    rst_n = 1'b0;
    #1;
    check("midrst_busy", busy, 1'b0);
    check("midrst_result", cur_res(), mk(0, 0, 0, 0, 0, 0));
    @(posedge clk); #1; rst_n = 1'b1;
    send_px(MATCH_A, 1'b0, 1'b1, 1'b0);
    check("post_rst_no_sof", busy, 1'b0);
    sb_q.push_back(mk(0, 7, 0, 3, 32, 1));
    send_frame(2, -1, 4);
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
